// File: rtl/nested_loop_counter_pkg.sv
// Shared types and defaults for the nested loop counter and related address generators.
package nested_loop_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_NUM_LEVELS    = 3;
    localparam int unsigned DEF_COUNTER_WIDTH = 4;

endpackage

// File: rtl/nested_loop_counter_level.sv
// One loop level: index register with inclusive-bound compare and carry chaining.
module loop_level_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] bound,
    output logic [WIDTH-1:0] idx,
    output logic             at_bound,
    output logic             carry_out,
    output logic             wrap
);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (carry_in) begin
            idx <= at_bound ? '0 : idx + 1'b1;
        end
    end

    assign at_bound  = (idx == bound);
    assign carry_out = carry_in & at_bound;
    assign wrap      = carry_out;

endmodule

// File: rtl/nested_loop_counter.sv
// Multi-level nested loop counter; level 0 innermost, start/step handshake, wrap and done pulses.
module nested_loop_counter
    import nested_loop_counter_pkg::*;
#(
    parameter int unsigned NUM_LEVELS    = DEF_NUM_LEVELS,
    parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_ld_i,
    input  logic [NUM_LEVELS*COUNTER_WIDTH-1:0] cfg_bound_i,
    input  logic                                start_i,
    input  logic                                step_i,
    output logic [NUM_LEVELS*COUNTER_WIDTH-1:0] count_o,
    output logic                                busy_o,
    output logic                                last_o,
    output logic [NUM_LEVELS-1:0]               level_wrap_o,
    output logic                                done_o
);

    localparam int unsigned BUS_W = NUM_LEVELS * COUNTER_WIDTH;

    state_t                state;
    state_t                state_next;
    logic [BUS_W-1:0]      bound_q;
    logic [NUM_LEVELS-1:0] at_bound;
    logic [NUM_LEVELS-1:0] wrap;
    logic [NUM_LEVELS-1:0] level_wrap_q;
    logic [NUM_LEVELS:0]   carry;
    logic                  done_q;
    logic                  busy;

    assign busy = (state == ST_RUN);

    // start_i takes priority over step_i, so a restart never advances or pulses.
    assign carry[0] = busy & step_i & ~start_i;

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start_i) state_next = ST_RUN;
            ST_RUN: begin
                if (start_i) begin
                    state_next = ST_RUN;
                end else if (carry[NUM_LEVELS]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            bound_q      <= '1;
            level_wrap_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state <= state_next;
            if (cfg_ld_i && state == ST_IDLE) begin
                bound_q <= cfg_bound_i;
            end
            level_wrap_q <= wrap;
            done_q       <= carry[NUM_LEVELS];
        end
    end

    for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_level
        loop_level_stage #(
            .WIDTH(COUNTER_WIDTH)
        ) u_level (
            .clk      (clk_i),
            .rst      (rst_i),
            .clr      (start_i),
            .carry_in (carry[k]),
            .bound    (bound_q[k*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .idx      (count_o[k*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .at_bound (at_bound[k]),
            .carry_out(carry[k+1]),
            .wrap     (wrap[k])
        );
    end

    assign busy_o       = busy;
    assign last_o       = busy & (&at_bound);
    assign level_wrap_o = level_wrap_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter with hand-computed expected indices and pulses.
module tb_nested_loop_counter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_ld_i = 1'b0;
    logic [11:0] cfg_bound_i = '0;
    logic        start_i = 1'b0;
    logic        step_i = 1'b0;
    logic [11:0] count_o;
    logic        busy_o;
    logic        last_o;
    logic [2:0]  level_wrap_o;
    logic        done_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nested_loop_counter #(
        .NUM_LEVELS   (3),
        .COUNTER_WIDTH(4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cfg_ld_i    (cfg_ld_i),
        .cfg_bound_i (cfg_bound_i),
        .start_i     (start_i),
        .step_i      (step_i),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .last_o      (last_o),
        .level_wrap_o(level_wrap_o),
        .done_o      (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, w1, dn, e, gap;
        int unsigned expv;

        // reset values
        cyc();
        rst_i = 1'b0;
        check("rst_count", count_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wrap", level_wrap_o, 0);
        check("rst_done", done_o, 0);
        check("rst_last", last_o, 0);

        // reset mid-run, bounds L0=2 L1=1 L2=1
        cfg_bound_i = 12'h112; cfg_ld_i = 1'b1; cyc(); cfg_ld_i = 1'b0;
        start_i = 1'b1; cyc(); start_i = 1'b0;
        step_i = 1'b1; repeat (3) cyc(); step_i = 1'b0;
        check("t1_cnt3", count_o, 12'h010);
        rst_i = 1'b1; start_i = 1'b1; step_i = 1'b1; cfg_ld_i = 1'b1; cfg_bound_i = 12'h000;
        cyc();
        rst_i = 1'b0; start_i = 1'b0; step_i = 1'b0; cfg_ld_i = 1'b0;
        check("t1_cnt", count_o, 0);
        check("t1_busy", busy_o, 0);
        check("t1_wrap", level_wrap_o, 0);
        check("t1_done", done_o, 0);
        // bounds back to F: level 0 runs to 15 before wrapping
        start_i = 1'b1; cyc(); start_i = 1'b0;
        step_i = 1'b1; repeat (15) cyc();
        check("t1_cnt15", count_o, 12'h00F);
        check("t1_nowrap", level_wrap_o, 0);
        cyc(); step_i = 1'b0;
        check("t1_cnt16", count_o, 12'h010);
        check("t1_wrap16", level_wrap_o, 3'b001);
        rst_i = 1'b1; cyc(); rst_i = 1'b0;

        // full sweep with bounds L2=1 L1=2 L0=3
        cfg_bound_i = 12'h123; cfg_ld_i = 1'b1; cyc(); cfg_ld_i = 1'b0;
        start_i = 1'b1; cyc(); start_i = 1'b0;
        check("t2_busy0", busy_o, 1);
        check("t2_cnt0", count_o, 0);
        w0 = 0; w1 = 0; dn = 0;
        step_i = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            check("t2_last", last_o, (n == 24) ? 1 : 0);
            cyc();
            e = n % 24;
            expv = (e / 12) * 256 + ((e / 4) % 3) * 16 + (e % 4);
            check("t2_cnt", count_o, expv);
            check("t2_wrap", level_wrap_o,
                  {29'd0, n == 24, (n % 12) == 0, (n % 4) == 0});
            check("t2_done", done_o, (n == 24) ? 1 : 0);
            check("t2_busy", busy_o, (n < 24) ? 1 : 0);
            w0 += int'(level_wrap_o[0]);
            w1 += int'(level_wrap_o[1]);
            dn += int'(done_o);
        end
        step_i = 1'b0;
        check("t2_w0cnt", w0, 6);
        check("t2_w1cnt", w1, 2);
        check("t2_dncnt", dn, 1);

        // all bounds zero, load and start together
        cfg_bound_i = 12'h000; cfg_ld_i = 1'b1; start_i = 1'b1; cyc();
        cfg_ld_i = 1'b0; start_i = 1'b0;
        check("t3_busy", busy_o, 1);
        check("t3_last", last_o, 1);
        step_i = 1'b1; cyc();
        check("t3_done", done_o, 1);
        check("t3_wrap", level_wrap_o, 3'b111);
        check("t3_busy_end", busy_o, 0);
        check("t3_cnt", count_o, 0);
        cyc(); step_i = 1'b0;
        check("t3_idle_wrap", level_wrap_o, 0);
        check("t3_idle_done", done_o, 0);
        check("t3_idle_cnt", count_o, 0);
        check("t3_idle_busy", busy_o, 0);

        // restart in RUN with simultaneous step
        cfg_bound_i = 12'h111; cfg_ld_i = 1'b1; cyc(); cfg_ld_i = 1'b0;
        start_i = 1'b1; cyc(); start_i = 1'b0;
        step_i = 1'b1; repeat (3) cyc();
        check("t4_cnt3", count_o, 12'h011);
        start_i = 1'b1; cyc(); start_i = 1'b0; step_i = 1'b0;
        check("t4_cnt", count_o, 0);
        check("t4_busy", busy_o, 1);
        check("t4_wrap", level_wrap_o, 0);
        check("t4_done", done_o, 0);

        // config load during RUN is ignored
        cfg_bound_i = 12'h000; cfg_ld_i = 1'b1; cyc(); cfg_ld_i = 1'b0;
        check("t5_last", last_o, 0);
        step_i = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            check("t5_cnt", count_o, (n % 8 / 4) * 256 + (n % 4 / 2) * 16 + (n % 2));
            check("t5_done", done_o, (n == 8) ? 1 : 0);
            check("t5_busy", busy_o, (n < 8) ? 1 : 0);
        end
        step_i = 1'b0;

        // full 16x16x16 sweep with random gaps
        cfg_bound_i = 12'hFFF; cfg_ld_i = 1'b1; cyc(); cfg_ld_i = 1'b0;
        start_i = 1'b1; cyc(); start_i = 1'b0;
        dn = 0;
        for (int n = 1; n <= 4096; n++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                cyc();
                dn += int'(done_o);
            end
            step_i = 1'b1; cyc(); step_i = 1'b0;
            dn += int'(done_o);
            check("t6_cnt", count_o, n % 4096);
            if (n == 4096) begin
                check("t6_done", done_o, 1);
                check("t6_busy", busy_o, 0);
            end
        end
        repeat (3) begin
            cyc();
            dn += int'(done_o);
        end
        check("t6_dncnt", dn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
